// File: rtl/seg7_pkg.sv
// Shared seven-segment constants, snapshot record and binary-to-BCD helper
// for the egg-timer display path. All glyphs are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // BCD code reserved for "value out of range"; decodes to SEG_DASH.
    localparam logic [3:0] BCD_DASH  = 4'hF;

    // Digit glyphs 9..0, element 0 is the glyph for "0".
    localparam logic [9:0][6:0] DIGIT_GLYPH = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Digit index doubles as the anode bit position (3 = leftmost).
    localparam logic [1:0] DIG_SEC_O = 2'd0;
    localparam logic [1:0] DIG_SEC_T = 2'd1;
    localparam logic [1:0] DIG_MIN_O = 2'd2;
    localparam logic [1:0] DIG_MIN_T = 2'd3;

    typedef struct packed {
        logic [5:0]      minutes;
        logic [5:0]      seconds;
        logic            counting;
        logic            override;
        logic [3:0][6:0] ovr;       // ovr[3] = D ... ovr[0] = E
    } snap_t;

    // Splits 0..59 into {tens, ones}; 60..63 yields two dash codes.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        if (v > 6'd59) begin
            return {BCD_DASH, BCD_DASH};
        end
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment glyph; BCD_DASH gives a dash
// and any other non-decimal code blanks the digit.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        if (bcd == BCD_DASH) begin
            glyph = SEG_DASH;
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (bcd == 4'(i)) begin
                    glyph = DIGIT_GLYPH[i];
                end
            end
        end
    end

endmodule

// File: rtl/display_scan_mux.sv
// Four-digit common-anode scan driver for the egg timer: frame-coherent
// snapshot of MM:SS or the DONE override, one blank cycle between digits.
module display_scan_mux
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV     = 100000,
    parameter int BLINK_DIV       = 50000000,
    parameter bit BLANK_LEAD_ZERO = 1'b0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] q_minutes,
    input  logic [5:0] q_seconds,
    input  logic       counting,
    input  logic [6:0] ovr_d,
    input  logic [6:0] ovr_o,
    input  logic [6:0] ovr_n,
    input  logic [6:0] ovr_e,
    output logic [3:0] anode,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int REFRESH_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_DIV - 1);
    localparam logic [BLINK_W-1:0]   BLINK_LAST   = BLINK_W'(BLINK_DIV - 1);

    logic [REFRESH_W-1:0] refresh_cnt_reg;
    logic [1:0]           digit_idx_reg;
    logic [BLINK_W-1:0]   blink_cnt_reg;
    logic                 blink_phase_reg;
    snap_t                snap_reg;
    snap_t                snap_next;
    logic [3:0]           anode_reg, anode_next;
    logic [6:0]           seg_reg, seg_next;
    logic                 dp_reg, dp_next;

    logic                 refresh_wrap;
    logic                 frame_wrap;
    logic                 blink_wrap;
    logic [3:0][6:0]      ovr_in;
    logic [3:0]           ovr_active;
    logic [3:0]           digit_sel;
    logic [7:0]           min_bcd;
    logic [7:0]           sec_bcd;
    logic [3:0]           digit_bcd;
    logic [6:0]           digit_glyph;

    assign refresh_wrap = (refresh_cnt_reg == REFRESH_LAST);
    assign frame_wrap   = refresh_wrap && (digit_idx_reg == DIG_MIN_T);
    assign blink_wrap   = (blink_cnt_reg == BLINK_LAST);

    assign ovr_in[3] = ovr_d;
    assign ovr_in[2] = ovr_o;
    assign ovr_in[1] = ovr_n;
    assign ovr_in[0] = ovr_e;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign ovr_active[gi] = (ovr_in[gi] != SEG_BLANK);
            assign digit_sel[gi]  = (digit_idx_reg != 2'(gi));
        end
    endgenerate

    always_comb begin
        snap_next.minutes  = q_minutes;
        snap_next.seconds  = q_seconds;
        snap_next.counting = counting;
        snap_next.override = |ovr_active;
        snap_next.ovr      = ovr_in;
    end

    // Digit values come from the registered snapshot only, so a frame never tears.
    assign min_bcd = to_bcd(snap_reg.minutes);
    assign sec_bcd = to_bcd(snap_reg.seconds);

    always_comb begin
        digit_bcd = sec_bcd[3:0];
        unique case (digit_idx_reg)
            DIG_MIN_T: digit_bcd = min_bcd[7:4];
            DIG_MIN_O: digit_bcd = min_bcd[3:0];
            DIG_SEC_T: digit_bcd = sec_bcd[7:4];
            DIG_SEC_O: digit_bcd = sec_bcd[3:0];
            default:   digit_bcd = sec_bcd[3:0];
        endcase
    end

    seg7_decode u_decode (
        .bcd   (digit_bcd),
        .glyph (digit_glyph)
    );

    // The wrap cycle loads an all-off frame so the next digit never ghosts.
    always_comb begin
        anode_next = ANODE_OFF;
        seg_next   = SEG_BLANK;
        dp_next    = 1'b1;
        if (!refresh_wrap) begin
            anode_next = digit_sel;
            if (snap_reg.override) begin
                seg_next = blink_phase_reg ? SEG_BLANK : snap_reg.ovr[digit_idx_reg];
            end else begin
                if (BLANK_LEAD_ZERO && (digit_idx_reg == DIG_MIN_T)
                        && (min_bcd[7:4] == 4'd0)) begin
                    seg_next = SEG_BLANK;
                end else begin
                    seg_next = digit_glyph;
                end
                dp_next = !((digit_idx_reg == DIG_MIN_O) && snap_reg.counting
                            && !blink_phase_reg);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            refresh_cnt_reg <= '0;
            digit_idx_reg   <= 2'd0;
        end else if (refresh_wrap) begin
            refresh_cnt_reg <= '0;
            digit_idx_reg   <= digit_idx_reg + 2'd1;
        end else begin
            refresh_cnt_reg <= refresh_cnt_reg + REFRESH_W'(1);
        end
    end

    // Free-running so mode changes never disturb the blink cadence.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (blink_wrap) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= !blink_phase_reg;
        end else begin
            blink_cnt_reg   <= blink_cnt_reg + BLINK_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            snap_reg <= '0;
        end else if (frame_wrap) begin
            snap_reg <= snap_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            anode_reg <= ANODE_OFF;
            seg_reg   <= SEG_BLANK;
            dp_reg    <= 1'b1;
        end else begin
            anode_reg <= anode_next;
            seg_reg   <= seg_next;
            dp_reg    <= dp_next;
        end
    end

    assign anode = anode_reg;
    assign seg   = seg_reg;
    assign dp    = dp_reg;

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Consumes the egg-timer controller's outputs: q_minutes/q_seconds counter values and the four override glyphs (D/O/N/E).
- Drives a 4-digit common-anode seven-segment display by time-multiplexing.
- Converts MM:SS binary values to BCD glyphs, snapshots the inputs once per scan frame to prevent tearing, and blinks the "DONE" override at a fixed rate.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays selected; legal range ≥ 2.
- BLINK_DIV, 50000000: clock cycles per half-period of the DONE blink and the colon blink; legal range ≥ 2.
- BLANK_LEAD_ZERO, 0: when 1, a minutes-tens digit of 0 shows blank.

Ports:
- clock  in  1  system clock; all state is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- q_minutes  in  6  minute count, binary 0..63.
- q_seconds  in  6  second count, binary 0..63.
- counting  in  1  high while the timer is counting down; enables the colon blink.
- ovr_d  in  7  override glyph for digit 3 (leftmost); 7'h7F means no override.
- ovr_o  in  7  override glyph for digit 2.
- ovr_n  in  7  override glyph for digit 1.
- ovr_e  in  7  override glyph for digit 0 (rightmost).
- anode  out  4  digit select, active-low; bit 3 is the leftmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; used as the MM:SS colon on digit 2.

Behaviour:
- Reset (asynchronous assert): anode=4'b1111, seg=7'h7F, dp=1, all counters 0, digit index 0, snapshot registers 0, blink phase 0. Release is synchronous to clock.
- All outputs are registered.
- Refresh counter runs 0..REFRESH_DIV-1. On the wrap cycle the digit index advances 0→1→2→3→0.
- Anti-ghosting:
  - On the cycle after the digit index advances, anode=4'b1111 for exactly 1 cycle.
  - On the following cycle, anode selects the new digit with its seg/dp.
  - The blank cycle counts within the REFRESH_DIV dwell.
- Snapshot: when the index wraps 3→0, latch q_minutes, q_seconds, counting, all four ovr_* and an override flag. Inputs are sampled on that wrap cycle.
  - Override flag = any ovr_* ≠ 7'h7F.
  - The first frame after reset displays the reset snapshot: "00:00", no override.
- BCD conversion of snapshot values:
  - Value v in 0..59: tens = v/10, ones = v%10, derived combinationally from the registered snapshot.
  - Value 60..63: both digits show dash 7'b0111111.
- Digit mapping, normal mode: digit3 = minutes tens, digit2 = minutes ones, digit1 = seconds tens, digit0 = seconds ones.
  - BLANK_LEAD_ZERO=1 and minutes tens = 0: digit3 seg=7'h7F.
- Colon: dp=0 on digit 2 only while counting_snap=1 and blink phase=0. Otherwise dp=1.
- Override mode (override flag set):
  - Digits 3..0 show ovr_d, ovr_o, ovr_n, ovr_e; dp=1.
  - When blink phase=1, seg=7'h7F on all digits while the anode scan continues.
- Blink counter runs 0..BLINK_DIV-1 and toggles the blink phase on wrap. It is free-running from reset and unaffected by mode changes.
- Mid-frame input changes: no effect until the next 3→0 wrap.
- Simultaneous override and counting: override wins; colon suppressed.
- Glyphs 0-9 use the standard active-low gfedcba encoding (e.g., 0=7'b1000000, 8=7'b0000000).

Decomposition:
- Shared package seg7_pkg:
  - SEG_BLANK=7'h7F, SEG_DASH=7'b0111111.
  - 10-entry digit glyph constant array.
  - ANODE_OFF=4'b1111.
  - Digit-index localparams (DIG_MIN_T, DIG_MIN_O, DIG_SEC_T, DIG_SEC_O).
- Sub-module seg7_decode: combinational 4-bit BCD → 7-bit active-low glyph, with input 4'hF returning SEG_DASH.
  - Instantiated once on the muxed digit value.

Test Plan (REFRESH_DIV=4, BLINK_DIV=16):
- Reset: hold reset_n=0 for 3 cycles → anode=1111, seg=7F, dp=1. After release, the first select is anode=0111 (digit 3) once digit 3 is reached, with seg=7'b1000000 ("0").
- q_minutes=5, q_seconds=42, counting=1, ovr_*=7F → after the next wrap, one frame shows:
  - digit3 = 7'b1000000
  - digit2 = 7'b0010010 with dp=0 while blink phase=0
  - digit1 = 7'b0011001
  - digit0 = 7'b0100100
  - 1 all-off cycle between digits.
- q_seconds=61 → digit1 and digit0 both show 7'b0111111.
- ovr_d/o/n/e = 1100000/1000000/1001000/0000110 → after the next wrap the glyphs appear on digits 3..0. Over 32 cycles, seg alternates between glyphs and 7F every 16 cycles; dp stays 1.
- Change q_seconds from 10 to 11 mid-frame (digit index 1) → digit0 still shows "0" until the 3→0 wrap, then shows "1".
- Assert reset_n=0 mid-frame during an override blink → outputs go to reset values immediately, without waiting for clock. After release, the display is in normal mode with "00:00".
